// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared CPU types (arbiter state encoding used by the arbiter and memory_control bench)
package cpu_types_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    IACC = 2'b01,
    DACC = 2'b10
  } arb_state_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side request ports plus RAM port of the memory arbiter
interface mem_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              iREN, iwait, dREN, dWEN, dwait, ramREN, ramWEN, ram_ack;
  logic [ADDR_W-1:0] iaddr, daddr, ramaddr;
  logic [DATA_W-1:0] iload, dload, dstore, ramstore, ramload;
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ack,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ack,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter_starve_guard.sv
// starve_guard: counts consecutive data grants taken while a fetch waits (MEM_ARB_STARVE_GUARD_EN)
`ifdef MEM_ARB_STARVE_GUARD_EN
module starve_guard #(parameter int STARVE_MAX = 4) (
  input  logic CLK,
  input  logic nRST,
  input  logic grant_d,
  input  logic grant_i,
  input  logic ireq,
  output logic force_i
);
  logic [2:0] cnt;
  // saturating count of data grants that bypassed a pending fetch
  always_ff @(posedge CLK, negedge nRST)
    if (!nRST) cnt <= '0;
    else if (grant_i || (grant_d && !ireq)) cnt <= '0;
    else if (grant_d && cnt != 3'd7) cnt <= cnt + 3'd1;
  assign force_i = ireq && (int'(cnt) >= STARVE_MAX);
endmodule
`endif

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between fetch and data; data has priority (MEM_ARB_STARVE_GUARD_EN bounds fetch starvation)
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
`ifdef MEM_ARB_STARVE_GUARD_EN
  , parameter int STARVE_MAX = 4
`endif
) (
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.slave bus
);
  arb_state_t state, nextState;
  logic dReq, forceI;
  assign dReq = bus.dREN | bus.dWEN;
`ifdef MEM_ARB_STARVE_GUARD_EN
  logic grantD, grantI;
  assign grantD = (state == IDLE) && (nextState == DACC);
  assign grantI = (state == IDLE) && (nextState == IACC);
  starve_guard #(.STARVE_MAX(STARVE_MAX)) guard (
    .CLK(CLK), .nRST(nRST), .grant_d(grantD), .grant_i(grantI), .ireq(bus.iREN), .force_i(forceI)
  );
`else
  assign forceI = 1'b0;
`endif
  // grant register; an async reset drops any in-flight access
  always_ff @(posedge CLK, negedge nRST)
    if (!nRST) state <= IDLE;
    else state <= nextState;
  // grant decision and RAM/requester muxing for the granted side
  always_comb begin
    nextState    = state;
    bus.iwait    = 1'b1;
    bus.dwait    = 1'b1;
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = ADDR_W'(0);
    bus.ramstore = DATA_W'(0);
    bus.iload    = DATA_W'(0);
    bus.dload    = DATA_W'(0);
    case (state)
      IDLE: nextState = (dReq && !forceI) ? DACC : bus.iREN ? IACC : IDLE;
      IACC: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
        bus.iload   = bus.ramload;
        bus.iwait   = !(bus.iREN && bus.ram_ack);
        nextState   = (bus.ram_ack || !bus.iREN) ? IDLE : IACC;
      end
      DACC: begin
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN && !bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.dload    = bus.ramload;
        bus.dwait    = !(dReq && bus.ram_ack);
        nextState    = (bus.ram_ack || !dReq) ? IDLE : DACC;
      end
      default: nextState = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors, random traffic vs. a transaction model, async reset and starvation checks
`timescale 1ns/1ps
module tb_mem_arbiter;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int tests = 0;
  int fails = 0;
  int own = 0;
  int cnt = 0;
  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  mem_arbiter dut (.CLK(CLK), .nRST(nRST), .bus(bus.slave));
  always #5 CLK = ~CLK;
  typedef struct packed {
    logic iw, dw, rr, rw;
    logic [31:0] addr, store, il, dl;
  } out_t;
  typedef struct {
    logic iR, dR, dW, ack;
    logic [31:0] daddr, rload;
    out_t e;
  } vec_t;
  vec_t tbl[$];
  function automatic vec_t v(logic iR, logic dR, logic dW, logic ack, logic [31:0] daddr, logic [31:0] rload,
                             logic iw, logic dw, logic rr, logic rw, logic [31:0] addr, logic [31:0] store,
                             logic [31:0] il, logic [31:0] dl);
    vec_t r;
    r.iR = iR; r.dR = dR; r.dW = dW; r.ack = ack; r.daddr = daddr; r.rload = rload;
    r.e = {iw, dw, rr, rw, addr, store, il, dl};
    return r;
  endfunction
  // outputs the specification prescribes for the current owner of the RAM
  function automatic out_t expect_out(int who);
    out_t e;
    e = '0;
    e.iw = 1'b1;
    e.dw = 1'b1;
    if (who == 1) begin
      e.rr = 1'b1;
      e.addr = bus.iaddr;
      e.il = bus.ramload;
      e.iw = !(bus.iREN && bus.ram_ack);
    end else if (who == 2) begin
      e.rw = bus.dWEN;
      e.rr = bus.dREN && !bus.dWEN;
      e.addr = bus.daddr;
      e.store = bus.dstore;
      e.dl = bus.ramload;
      e.dw = !((bus.dREN || bus.dWEN) && bus.ram_ack);
    end
    return e;
  endfunction
  // ownership changes at the clock edge: grant from idle, release on ack or withdrawal
  function automatic void step_model();
    bit dreq = bus.dREN || bus.dWEN;
    bit force_i = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    force_i = bus.iREN && cnt >= 4;
`endif
    if (own == 0) begin
      if (dreq && !force_i) begin
        own = 2;
        cnt = bus.iREN ? (cnt < 7 ? cnt + 1 : 7) : 0;
      end else if (bus.iREN) begin
        own = 1;
        cnt = 0;
      end
    end else if (own == 1) begin
      if (!bus.iREN || bus.ram_ack) own = 0;
    end else if (!dreq || bus.ram_ack) own = 0;
  endfunction
  task automatic check(string name, out_t e);
    out_t a;
    a = {bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore, bus.iload, bus.dload};
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got iw=%b dw=%b rr=%b rw=%b addr=%h st=%h il=%h dl=%h, want iw=%b dw=%b rr=%b rw=%b addr=%h st=%h il=%h dl=%h",
               name, a.iw, a.dw, a.rr, a.rw, a.addr, a.store, a.il, a.dl, e.iw, e.dw, e.rr, e.rw, e.addr, e.store, e.il, e.dl);
    end
  endtask
  task automatic do_reset();
    nRST = 1'b0;
    bus.iREN = 0; bus.dREN = 0; bus.dWEN = 0; bus.ram_ack = 0;
    bus.iaddr = 0; bus.daddr = 0; bus.dstore = 0; bus.ramload = 0;
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    own = 0;
    cnt = 0;
    @(posedge CLK);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish before 100000ns");
    $fatal(1, "timeout");
  end
  initial begin
    int got;
    tbl.push_back(v(1,0,0,0,32'h0,  32'h0,       1,1,0,0,32'h0,  32'h0,       32'h0,       32'h0));
    tbl.push_back(v(1,0,0,0,32'h0,  32'h8C010004,1,1,1,0,32'h40, 32'h0,       32'h8C010004,32'h0));
    tbl.push_back(v(1,0,0,0,32'h0,  32'h8C010004,1,1,1,0,32'h40, 32'h0,       32'h8C010004,32'h0));
    tbl.push_back(v(1,0,0,1,32'h0,  32'h8C010004,0,1,1,0,32'h40, 32'h0,       32'h8C010004,32'h0));
    tbl.push_back(v(0,0,0,0,32'h0,  32'h8C010004,1,1,0,0,32'h0,  32'h0,       32'h0,       32'h0));
    tbl.push_back(v(1,1,0,0,32'h100,32'h0,       1,1,0,0,32'h0,  32'h0,       32'h0,       32'h0));
    tbl.push_back(v(1,1,0,0,32'h100,32'h11112222,1,1,1,0,32'h100,32'hDEADBEEF,32'h0,       32'h11112222));
    tbl.push_back(v(1,1,0,1,32'h100,32'h11112222,1,0,1,0,32'h100,32'hDEADBEEF,32'h0,       32'h11112222));
    tbl.push_back(v(1,0,0,0,32'h100,32'h0,       1,1,0,0,32'h0,  32'h0,       32'h0,       32'h0));
    tbl.push_back(v(1,0,0,1,32'h100,32'h33334444,0,1,1,0,32'h40, 32'h0,       32'h33334444,32'h0));
    tbl.push_back(v(0,0,0,0,32'h0,  32'h0,       1,1,0,0,32'h0,  32'h0,       32'h0,       32'h0));
    tbl.push_back(v(0,0,1,0,32'h200,32'h0,       1,1,0,0,32'h0,  32'h0,       32'h0,       32'h0));
    tbl.push_back(v(0,0,1,0,32'h200,32'h0,       1,1,0,1,32'h200,32'hDEADBEEF,32'h0,       32'h0));
    tbl.push_back(v(0,0,1,1,32'h200,32'h0,       1,0,0,1,32'h200,32'hDEADBEEF,32'h0,       32'h0));
    tbl.push_back(v(0,0,0,0,32'h200,32'h0,       1,1,0,0,32'h0,  32'h0,       32'h0,       32'h0));
    tbl.push_back(v(0,1,0,0,32'h100,32'h0,       1,1,0,0,32'h0,  32'h0,       32'h0,       32'h0));
    tbl.push_back(v(0,1,0,0,32'h100,32'h55556666,1,1,1,0,32'h100,32'hDEADBEEF,32'h0,       32'h55556666));
    tbl.push_back(v(0,0,0,0,32'h100,32'h55556666,1,1,0,0,32'h100,32'hDEADBEEF,32'h0,       32'h55556666));
    tbl.push_back(v(0,0,0,1,32'h100,32'h55556666,1,1,0,0,32'h0,  32'h0,       32'h0,       32'h0));
    tbl.push_back(v(0,1,0,0,32'h100,32'h0,       1,1,0,0,32'h0,  32'h0,       32'h0,       32'h0));
    tbl.push_back(v(0,1,0,1,32'h100,32'h77778888,1,0,1,0,32'h100,32'hDEADBEEF,32'h0,       32'h77778888));
    do_reset();
    check("reset", expect_out(0));
    bus.iaddr = 32'h40;
    bus.dstore = 32'hDEADBEEF;
    foreach (tbl[k]) begin
      bus.iREN = tbl[k].iR; bus.dREN = tbl[k].dR; bus.dWEN = tbl[k].dW; bus.ram_ack = tbl[k].ack;
      bus.daddr = tbl[k].daddr; bus.ramload = tbl[k].rload;
      @(negedge CLK);
      check($sformatf("vec%0d", k), tbl[k].e);
      @(posedge CLK);
      #1;
    end
    do_reset();
    for (int n = 0; n < 400; n++) begin
      bus.iREN = $urandom_range(0, 9) < 7;
      bus.dREN = $urandom_range(0, 9) < 4;
      bus.dWEN = $urandom_range(0, 9) < 2;
      bus.ram_ack = $urandom_range(0, 2) == 0;
      bus.iaddr = $urandom; bus.daddr = $urandom; bus.dstore = $urandom; bus.ramload = $urandom;
      @(negedge CLK);
      check($sformatf("rand%0d", n), expect_out(own));
      step_model();
      @(posedge CLK);
      #1;
    end
    do_reset();
    bus.iREN = 1; bus.iaddr = 32'h40; bus.ramload = 32'h12345678;
    @(negedge CLK);
    check("ar_idle", expect_out(0));
    @(posedge CLK);
    #1;
    @(negedge CLK);
    check("ar_iacc", expect_out(1));
    #1 nRST = 1'b0;
    #1 check("ar_async", expect_out(0));
    #1 nRST = 1'b1;
    #1 check("ar_release", expect_out(0));
    @(posedge CLK);
    #1 check("ar_regrant", expect_out(1));
    do_reset();
    bus.iREN = 1; bus.dREN = 1; bus.ram_ack = 1;
    bus.iaddr = 32'h40; bus.daddr = 32'h100;
    got = 0;
    for (int c = 0; c < 80 && got < 10; c++) begin
      @(negedge CLK);
      if (bus.ramREN) begin
        bit exp_i = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_i = (got % 5) == 4;
`endif
        tests++;
        if ((bus.ramaddr == 32'h40) !== exp_i) begin
          fails++;
          $display("FAIL starve%0d: got fetch_granted=%b, want %b", got, bus.ramaddr == 32'h40, exp_i);
        end
        got++;
      end
      @(posedge CLK);
      #1;
    end
    tests++;
    if (got < 10) begin
      fails++;
      $display("FAIL starve_count: got %0d grants, want 10", got);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares a single-port main RAM between the instruction-fetch requester and the data-access requester of the pipelined MIPS core.
- Sits between the cache-side request ports and the RAM.
- Grants one requester at a time through a small FSM.
- Holds the grant until the RAM acknowledges.
- Returns wait/load to the granted side and keeps the other side stalled.
- Data accesses have priority over fetches, so a memory-stage access is never starved by fetch.

Parameters:
ADDR_W, 32, address width in bits
DATA_W, 32, data width in bits
STARVE_MAX, 4, consecutive data grants allowed before a pending fetch is forced (used only with the optional feature)

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  reset, asynchronous, active-low
iREN  in  1  instruction read request, held until iwait low
iaddr  in  ADDR_W  instruction address
iwait  out  1  instruction stall; low only in the completing cycle
iload  out  DATA_W  instruction data, valid when iREN & !iwait
dREN  in  1  data read request, held until dwait low
dWEN  in  1  data write request, held until dwait low
daddr  in  ADDR_W  data address
dstore  in  DATA_W  data write value
dwait  out  1  data stall; low only in the completing cycle
dload  out  DATA_W  data read value, valid when dREN & !dwait
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  ADDR_W  RAM address
ramstore  out  DATA_W  RAM write data
ramload  in  DATA_W  RAM read data
ram_ack  in  1  RAM access complete this cycle

Behaviour:
- States:
  - IDLE: no requester granted.
  - IACC: instruction side granted.
  - DACC: data side granted.
- Reset state is IDLE.
- Reset values: iwait=1, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iload=0, dload=0.
- IDLE transitions (evaluated at the clock edge):
  - dREN|dWEN -> DACC.
  - else iREN -> IACC.
  - else stay in IDLE.
  - RAM strobes are 0 in IDLE; there is no same-cycle grant.
- IACC outputs:
  - ramREN=1, ramWEN=0, ramaddr=iaddr.
  - iload=ramload; iwait=!ram_ack; dwait=1.
- DACC outputs:
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=dWEN, ramREN=dREN&!dWEN (dREN&dWEN together is treated as a write).
  - dload=ramload; dwait=!ram_ack; iwait=1.
- Completion: ram_ack in IACC or DACC returns the FSM to IDLE next cycle. Back-to-back accesses therefore carry one idle cycle.
- Abort: if the granted request drops before ram_ack, the FSM returns to IDLE next cycle and the strobes go low. No wait-low is issued.
- Ignored acks: ram_ack in IDLE is ignored, as is any ack arriving after an abort.
- Waits outside the grant:
  - The non-granted side's wait is always 1.
  - Any side with no request sees wait=1.
- Simultaneous arrival of fetch and data in IDLE: data wins, fetch waits for the next IDLE decision.
- Reset asserted mid-access: the FSM and all outputs go to reset values immediately (async). The in-flight RAM access is dropped.
- Addresses pass through untranslated; there is no width conversion.
- Outputs are combinational from the state plus the granted inputs. Only the state (and the optional counter) is registered.

Optional Feature:
MEM_ARB_STARVE_GUARD_EN
- Defined:
  - A 3-bit saturating counter counts consecutive DACC grants while iREN is high at the grant decision.
  - When the counter reaches STARVE_MAX and iREN is high in IDLE, the arbiter grants IACC even if data is pending.
  - The counter clears on any IACC grant, and whenever iREN is low at a grant decision.
  - The counter resets to 0.
- Undefined: strict data priority; no counter logic is synthesized.

Decomposition:
- cpu_types_pkg holds arb_state_t (enum IDLE=2'b00, IACC=2'b01, DACC=2'b10).
- The package is shared with the memory_control bench for state checking.
- No sub-module for the base block.
- The optional counter is natural as sub-module starve_guard (CLK, nRST, grant_d, grant_i, ireq, force_i).

Test Plan:
1. Instruction fetch: iREN=1, iaddr=0x40, ram_ack on the 3rd access cycle, ramload=0x8C010004 -> ramREN=1 and ramaddr=0x40 from cycle 2; iwait low with iload=0x8C010004 in cycle 4 only; ramREN=0 in cycle 5.
2. Collision: iREN and dREN high together in IDLE, daddr=0x100 -> DACC first with dload returned; after one idle cycle IACC begins with ramaddr=iaddr.
3. Store: dWEN=1, daddr=0x200, dstore=0xDEADBEEF, ram_ack after 2 cycles -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dwait low for exactly 1 cycle.
4. Abort: dREN withdrawn in the 2nd DACC cycle before ram_ack -> IDLE next cycle, strobes 0, dwait stays 1; a late ram_ack is ignored.
5. Async reset: nRST pulsed low mid-IACC off the clock edge -> iwait=1 and ramREN=0 immediately; IDLE after release.
6. MEM_ARB_STARVE_GUARD_EN, STARVE_MAX=4: continuous dREN plus iREN -> 4 DACC grants, then 1 IACC grant, then the pattern repeats; without the macro, IACC is never granted.
